signal_debounce_edge: RTL and testbench
=======================================

SIGNAL_DEBOUNCE_EDGE -- requirements
Module: signal_debounce_edge

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 16: consecutive differing samples needed to accept a new level; legal range 1..65535.
REQ-002 The module SHALL have parameter INIT_LEVEL, default 1'b0: filtered level after reset.
REQ-003 The module SHALL have parameter EVT_W, default 16: event counter width.
REQ-004 The module SHALL have port clkB, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The module SHALL have port sig_in, input, 1 bit: level already synchronized into clkB; no further synchronization inside this block.
REQ-007 The module SHALL have port level_out, output, 1 bit: debounced level, registered.
REQ-008 The module SHALL have port rise_pulse, output, 1 bit: one-cycle pulse on accepted 0->1 change, registered.
REQ-009 The module SHALL have port fall_pulse, output, 1 bit: one-cycle pulse on accepted 1->0 change, registered.
REQ-010 The module SHALL have port evt_clr, input, 1 bit: synchronous clear of the event counter.
REQ-011 The module SHALL have port evt_count, output, EVT_W bits: count of accepted rising edges, registered.

Function
REQ-012 The module SHALL implement a four-state FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-013 In the STABLE_x states, a sample of sig_in differing from level_out SHALL move the FSM to the matching PEND_x state with stable counter = 1.
REQ-014 In a PEND_x state, a differing sample SHALL increment the counter, and a matching sample SHALL return the FSM to STABLE_x with counter = 0 (glitch rejected, no output change).
REQ-015 When the differing-sample count reaches STABLE_CYCLES, the module SHALL, on that same edge, toggle level_out, assert the matching pulse for exactly one cycle, clear the counter and enter the new STABLE_x state.
REQ-016 Latency: if sig_in first differs at sampling edge k and stays changed, level_out and the pulse SHALL change at edge k+STABLE_CYCLES-1.
REQ-017 STABLE_CYCLES = 1 SHALL give latency 1, with the PEND states never occupied.
REQ-018 The stable counter width SHALL be clog2(STABLE_CYCLES+1), and the counter SHALL never exceed STABLE_CYCLES.
REQ-019 rise_pulse and fall_pulse SHALL never be high in the same cycle.
REQ-020 A rise_pulse SHALL increment evt_count by 1, wrapping from 2^EVT_W-1 to 0.
REQ-021 evt_clr alone SHALL set evt_count to 0 at the next edge.
REQ-022 evt_clr coincident with rise_pulse SHALL set evt_count to 1.

Reset
REQ-023 While rst_n = 0 at an edge, the module SHALL force level_out = INIT_LEVEL, FSM = STABLE_LO or STABLE_HI per INIT_LEVEL, counter = 0, rise_pulse = fall_pulse = 0 and evt_count = 0.
REQ-024 Reset asserted mid-PEND SHALL discard the pending transition; after release, debouncing SHALL restart from INIT_LEVEL.
REQ-025 The first edge with rst_n = 1 SHALL sample sig_in normally, and no pulse SHALL result from reset itself.

Configuration
REQ-026 Macro SIGNAL_DEBOUNCE_EVT_COUNTER_EN defined SHALL include the event counter per REQ-020 to REQ-022.
REQ-027 Macro SIGNAL_DEBOUNCE_EVT_COUNTER_EN undefined SHALL retain the evt_clr and evt_count ports, ignore evt_clr, tie evt_count to 0 and infer no counter flops.

Structure
REQ-028 A shared package debounce_pkg SHALL hold the FSM state typedef (2-bit encoding) and the clog2 width-helper function.
REQ-029 The event counter SHALL be a sub-module, debounce_evt_counter (inputs clkB, rst_n, inc, clr; output count), instantiated only under the macro.

Verification
REQ-030 With STABLE_CYCLES = 4 and INIT_LEVEL = 0, sig_in rising at edge 10 and held SHALL give level_out = 1 and rise_pulse high for one cycle at edge 13, with evt_count = 1.
REQ-031 With STABLE_CYCLES = 4, a 3-cycle high glitch followed by low SHALL leave level_out = 0, produce no pulses and leave evt_count unchanged.
REQ-032 With STABLE_CYCLES = 4, rst_n = 0 asserted at the 2nd differing sample, then released with sig_in still high, SHALL give level_out = 0 through reset and level_out = 1 at the 4th post-reset edge.
REQ-033 With EVT_W = 4, 17 accepted rising edges SHALL give evt_count = 1.
REQ-034 evt_clr asserted in the same cycle as a rise_pulse, with prior count 7, SHALL give evt_count = 1.
REQ-035 With the macro undefined, REQ-030 stimulus SHALL give evt_count = 0 throughout, and level_out and pulses SHALL be identical to the macro-defined build.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the signal debouncer.
// The FSM state type uses a 2-bit encoding; clog2 sizes the stable counter.
package debounce_pkg;

  typedef enum logic [1:0] {
    StStableLo = 2'b00,
    StPendHi   = 2'b01,
    StStableHi = 2'b10,
    StPendLo   = 2'b11
  } deb_state_e;

  // Ceiling log2, for elaboration-time width calculation.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_evt_counter.sv
// Wrapping event counter with synchronous clear.
// A clear in the same cycle as an increment leaves the count at 1,
// so the coincident event is not lost.
module debounce_evt_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clkB,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority but still captures a coincident increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? W'(1) : '0;
    end else if (inc) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clkB) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/signal_debounce_edge.sv
// Debounces an already-synchronised level and emits one-cycle edge pulses.
// A new level is accepted after STABLE_CYCLES consecutive differing samples;
// a matching sample during the pending window rejects the glitch.
// Optional rising-edge event counter: define SIGNAL_DEBOUNCE_EVT_COUNTER_EN.
module signal_debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        INIT_LEVEL    = 1'b0,
  parameter int unsigned EVT_W         = 16
) (
  input  logic             clkB,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  input  logic             evt_clr,
  output logic [EVT_W-1:0] evt_count
);

  localparam int unsigned     CntW    = clog2(STABLE_CYCLES + 1);
  // Counter value seen on the edge that takes the final differing sample.
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  deb_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            rise_q;
  logic            fall_q;

  logic            differ;
  logic            accept;

  // Decide whether this edge's sample completes a qualified transition.
  always_comb begin
    differ = (sig_in != level_q);
    accept = 1'b0;
    case (state_q)
      StStableLo, StStableHi: accept = differ && (STABLE_CYCLES == 1);
      default:                accept = differ && (cnt_q == CntLast);
    endcase
  end

  // Debounce FSM with registered level and pulse outputs.
  always_ff @(posedge clkB) begin
    if (!rst_n) begin
      state_q <= INIT_LEVEL ? StStableHi : StStableLo;
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (accept) begin
        level_q <= sig_in;
        rise_q  <= sig_in;
        fall_q  <= ~sig_in;
        cnt_q   <= '0;
        state_q <= sig_in ? StStableHi : StStableLo;
      end else begin
        unique case (state_q)
          StStableLo: begin
            if (differ) begin
              state_q <= StPendHi;
              cnt_q   <= CntW'(1);
            end
          end
          StStableHi: begin
            if (differ) begin
              state_q <= StPendLo;
              cnt_q   <= CntW'(1);
            end
          end
          StPendHi: begin
            if (differ) begin
              cnt_q <= cnt_q + CntW'(1);
            end else begin
              state_q <= StStableLo;
              cnt_q   <= '0;
            end
          end
          StPendLo: begin
            if (differ) begin
              cnt_q <= cnt_q + CntW'(1);
            end else begin
              state_q <= StStableHi;
              cnt_q   <= '0;
            end
          end
        endcase
      end
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef SIGNAL_DEBOUNCE_EVT_COUNTER_EN
  logic rise_evt;

  // Counts on the same edge that raises rise_pulse.
  assign rise_evt = accept & sig_in;

  debounce_evt_counter #(
    .W (EVT_W)
  ) u_evt_counter (
    .clkB  (clkB),
    .rst_n (rst_n),
    .inc   (rise_evt),
    .clr   (evt_clr),
    .count (evt_count)
  );
`else
  logic unused_evt_clr;

  assign unused_evt_clr = evt_clr;
  assign evt_count      = '0;
`endif

endmodule

// File: tb/tb_signal_debounce_edge.sv
// Self-checking bench for signal_debounce_edge.
// Two instances share stimulus: STABLE_CYCLES=4/INIT 0 and STABLE_CYCLES=1/INIT 1,
// both with EVT_W=4. A window-based reference model predicts every output.
module tb_signal_debounce_edge;

  logic       clkB;
  logic       rst_n;
  logic       sig_in;
  logic       evt_clr;

  logic       lvl4, rise4, fall4;
  logic [3:0] cnt4;
  logic       lvl1, rise1, fall1;
  logic [3:0] cnt1;

  int checks;
  int errors;

  signal_debounce_edge #(
    .STABLE_CYCLES (4),
    .INIT_LEVEL    (1'b0),
    .EVT_W         (4)
  ) dut (
    .clkB       (clkB),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .level_out  (lvl4),
    .rise_pulse (rise4),
    .fall_pulse (fall4),
    .evt_clr    (evt_clr),
    .evt_count  (cnt4)
  );

  signal_debounce_edge #(
    .STABLE_CYCLES (1),
    .INIT_LEVEL    (1'b1),
    .EVT_W         (4)
  ) dut1 (
    .clkB       (clkB),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .level_out  (lvl1),
    .rise_pulse (rise1),
    .fall_pulse (fall1),
    .evt_clr    (evt_clr),
    .evt_count  (cnt1)
  );

  initial clkB = 1'b0;
  always #5 clkB = ~clkB;

  // Reference model: a level is accepted once the last S samples since reset all
  // differ from it. Index 0 models dut, index 1 models dut1.
  logic        m_lvl  [2];
  logic        m_rise [2];
  logic        m_fall [2];
  logic [3:0]  m_cnt  [2];
  logic [15:0] m_hist [2];
  int          m_n    [2];

  function automatic int s_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic init_of(input int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [3:0] exp_cnt(input logic [3:0] m);
`ifdef SIGNAL_DEBOUNCE_EVT_COUNTER_EN
    return m;
`else
    return 4'd0;
`endif
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic c);
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        m_lvl[i]  = init_of(i);
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        m_cnt[i]  = 4'd0;
        m_hist[i] = 16'd0;
        m_n[i]    = 0;
      end else begin
        logic [15:0] mask;
        logic [15:0] want;
        mask      = 16'((32'd1 << s_of(i)) - 1);
        m_hist[i] = {m_hist[i][14:0], s};
        if (m_n[i] < 16) m_n[i] = m_n[i] + 1;
        want      = m_lvl[i] ? 16'd0 : mask;
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (m_n[i] >= s_of(i) && (m_hist[i] & mask) == want) begin
          m_lvl[i]  = ~m_lvl[i];
          m_rise[i] = m_lvl[i];
          m_fall[i] = ~m_lvl[i];
        end
        if (c) m_cnt[i] = m_rise[i] ? 4'd1 : 4'd0;
        else   m_cnt[i] = m_cnt[i] + {3'd0, m_rise[i]};
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("lvl4",  16'(lvl4),  16'(m_lvl[0]));
    chk("rise4", 16'(rise4), 16'(m_rise[0]));
    chk("fall4", 16'(fall4), 16'(m_fall[0]));
    chk("cnt4",  16'(cnt4),  16'(exp_cnt(m_cnt[0])));
    chk("excl4", 16'(rise4 & fall4), 16'd0);
    chk("lvl1",  16'(lvl1),  16'(m_lvl[1]));
    chk("rise1", 16'(rise1), 16'(m_rise[1]));
    chk("fall1", 16'(fall1), 16'(m_fall[1]));
    chk("cnt1",  16'(cnt1),  16'(exp_cnt(m_cnt[1])));
  endtask

  // Drive inputs away from the edge, advance one edge, then check.
  task automatic step(input logic r, input logic s, input logic c);
    rst_n   = r;
    sig_in  = s;
    evt_clr = c;
    @(posedge clkB);
    model_edge(r, s, c);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic s, input int n);
    for (int k = 0; k < n; k++) step(1'b1, s, 1'b0);
  endtask

  typedef struct {
    logic       rst;
    logic       sig;
    logic       clr;
    logic       lvl;
    logic       rise;
    logic       fall;
    logic [3:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic c, input logic l,
                              input logic ri, input logic fa, input logic [3:0] n);
    vec_t v;
    v.rst = 1'b1; v.sig = s; v.clr = c; v.lvl = l; v.rise = ri; v.fall = fa; v.cnt = n;
    return v;
  endfunction

  vec_t tbl [20];

  initial begin
    logic cur;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    sig_in  = 1'b0;
    evt_clr = 1'b0;

    // Directed table for the STABLE_CYCLES=4 instance, starting right after reset.
    tbl[0]  = mk(0, 0, 0, 0, 0, 4'd0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 4'd0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 4'd0);  // first differing sample
    tbl[3]  = mk(1, 0, 0, 0, 0, 4'd0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 4'd0);
    tbl[5]  = mk(1, 0, 1, 1, 0, 4'd1);  // accepted S-1 edges later
    tbl[6]  = mk(1, 0, 1, 0, 0, 4'd1);
    tbl[7]  = mk(0, 0, 1, 0, 0, 4'd1);
    tbl[8]  = mk(1, 0, 1, 0, 0, 4'd1);  // one-sample glitch rejected
    tbl[9]  = mk(0, 0, 1, 0, 0, 4'd1);
    tbl[10] = mk(0, 0, 1, 0, 0, 4'd1);
    tbl[11] = mk(0, 0, 1, 0, 0, 4'd1);
    tbl[12] = mk(0, 0, 0, 0, 1, 4'd1);  // falling edge accepted
    tbl[13] = mk(0, 0, 0, 0, 0, 4'd1);
    tbl[14] = mk(1, 0, 0, 0, 0, 4'd1);  // 3-cycle high glitch
    tbl[15] = mk(1, 0, 0, 0, 0, 4'd1);
    tbl[16] = mk(1, 0, 0, 0, 0, 4'd1);
    tbl[17] = mk(0, 0, 0, 0, 0, 4'd1);
    tbl[18] = mk(0, 0, 0, 0, 0, 4'd1);
    tbl[19] = mk(0, 1, 0, 0, 0, 4'd0);  // clear alone

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("reset_lvl4", 16'(lvl4), 16'd0);
    chk("reset_lvl1", 16'(lvl1), 16'd1);
    chk("reset_cnt4", 16'(cnt4), 16'd0);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].sig, tbl[i].clr);
      chk($sformatf("tbl%0d_lvl", i),  16'(lvl4),  16'(tbl[i].lvl));
      chk($sformatf("tbl%0d_rise", i), 16'(rise4), 16'(tbl[i].rise));
      chk($sformatf("tbl%0d_fall", i), 16'(fall4), 16'(tbl[i].fall));
      chk($sformatf("tbl%0d_cnt", i),  16'(cnt4),  16'(exp_cnt(tbl[i].cnt)));
    end

    // Reset during a pending rise discards it; debouncing restarts afterwards.
    step(1'b0, 1'b0, 1'b0);
    hold(1'b0, 2);
    hold(1'b1, 1);
    step(1'b0, 1'b1, 1'b0);
    chk("rstpend_lvl_a", 16'(lvl4), 16'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("rstpend_lvl_b", 16'(lvl4), 16'd0);
    hold(1'b1, 3);
    chk("rstpend_lvl_c", 16'(lvl4), 16'd0);
    chk("rstpend_rise_c", 16'(rise4), 16'd0);
    hold(1'b1, 1);
    chk("rstpend_lvl_d", 16'(lvl4), 16'd1);
    chk("rstpend_rise_d", 16'(rise4), 16'd1);

    // 17 accepted rises wrap a 4-bit counter to 1.
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 17; k++) begin
      hold(1'b1, 4);
      hold(1'b0, 4);
    end
    chk("wrap17_cnt", 16'(cnt4), 16'(exp_cnt(4'd1)));

    // Clear coincident with a rise from a count of 7 leaves 1.
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      hold(1'b1, 4);
      hold(1'b0, 4);
    end
    chk("pre_clr_cnt7", 16'(cnt4), 16'(exp_cnt(4'd7)));
    hold(1'b1, 3);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_rise_pulse", 16'(rise4), 16'd1);
    chk("clr_rise_cnt", 16'(cnt4), 16'(exp_cnt(4'd1)));

    // Randomised run with bursty input, occasional clears and resets.
    cur = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) cur = ~cur;
      step(($urandom_range(0, 149) != 0), cur, ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
